// File: rtl/cache_ctrl.sv
// Direct-mapped cache tag controller: lookup, line fill via next level, flush.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module cache_ctrl #(
    parameter int TAG_W = 6,
    parameter int IDX_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic [TAG_W+IDX_W-1:0] cpu_addr,
    input  logic                   flush,
    output logic                   cpu_busy,
    output logic                   cpu_done,
    output logic                   cpu_hit,
    output logic [IDX_W-1:0]       tag_addr,
    output logic [TAG_W-1:0]       tag_din,
    output logic                   tag_dwr,
    input  logic [TAG_W-1:0]       tag_dout,
    output logic                   mem_req,
    input  logic                   mem_ack,
    output logic [7:0]             hit_cnt,
    output logic [7:0]             miss_cnt
);
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        UPDATE,
        DONE,
        FLUSH
    } state_t;

    state_t             state_reg, state_next;
    logic [TAG_W-1:0]   req_tag_reg;
    logic [IDX_W-1:0]   req_idx_reg;
    logic               hit_reg;
    logic [ENTRIES-1:0] valid_reg, valid_next;
    logic               lookup_hit;

    assign lookup_hit = valid_reg[req_idx_reg] && (tag_dout == req_tag_reg);

    // Per-entry valid update: flush clears everything, a fill marks its own line.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
        assign valid_next[gi] = (state_reg == FLUSH) ? 1'b0 :
                                ((state_reg == UPDATE) && (req_idx_reg == IDX_W'(gi))) ? 1'b1 :
                                valid_reg[gi];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (flush)
                    state_next = FLUSH;
                else if (cpu_req)
                    state_next = LOOKUP;
            end
            LOOKUP:  state_next = lookup_hit ? DONE : FILL;
            FILL:    if (mem_ack) state_next = UPDATE;
            UPDATE:  state_next = DONE;
            DONE:    state_next = IDLE;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            req_tag_reg <= '0;
            req_idx_reg <= '0;
            hit_reg     <= 1'b0;
            valid_reg   <= '0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            // flush wins over a simultaneous request, so the address is not captured then
            if ((state_reg == IDLE) && !flush && cpu_req) begin
                req_tag_reg <= cpu_addr[TAG_W+IDX_W-1:IDX_W];
                req_idx_reg <= cpu_addr[IDX_W-1:0];
            end
            if (state_reg == LOOKUP)
                hit_reg <= lookup_hit;
        end
    end

    assign cpu_busy = (state_reg != IDLE);
    assign cpu_done = (state_reg == DONE);
    assign cpu_hit  = (state_reg == DONE) && hit_reg;
    assign mem_req  = (state_reg == FILL);
    assign tag_dwr  = (state_reg == UPDATE);
    assign tag_addr = req_idx_reg;
    assign tag_din  = req_tag_reg;

`ifdef CACHE_STATS_EN
    logic [7:0] hit_cnt_reg, miss_cnt_reg;

    // Saturating counters; only reset clears them, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (state_reg == LOOKUP) begin
            if (lookup_hit && (hit_cnt_reg != 8'hFF))
                hit_cnt_reg <= hit_cnt_reg + 8'd1;
            if (!lookup_hit && (miss_cnt_reg != 8'hFF))
                miss_cnt_reg <= miss_cnt_reg + 8'd1;
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`else
    assign hit_cnt  = 8'd0;
    assign miss_cnt = 8'd0;
`endif

endmodule
